// File: rtl/game_pkg.sv
// Shared encodings for the pong game-flow controller: state codes, scan-code
// constants, winner codes and the lives-counter width helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        SERVE = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;

    function automatic int life_w(input int lives);
        return (lives < 1) ? 1 : $clog2(lives + 1);
    endfunction

endpackage

// File: rtl/bcd_score_ctr.sv
// Multi-digit BCD score counter: synchronous clear, increment that sticks at
// all nines. bcd_inc exposes the would-be next value for win detection.
module bcd_score_ctr #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [4*DIGITS-1:0] bcd,
    output logic [4*DIGITS-1:0] bcd_inc
);

    logic all_nines;
    logic carry;

    always_comb begin
        all_nines = 1'b1;
        for (int d = 0; d < DIGITS; d++)
            if (bcd[4*d +: 4] != 4'd9) all_nines = 1'b0;
        bcd_inc = bcd;
        carry   = !all_nines;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (bcd[4*d +: 4] == 4'd9) begin
                    bcd_inc[4*d +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*d +: 4] = bcd[4*d +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   bcd <= '0;
        else if (clr) bcd <= '0;
        else if (inc) bcd <= bcd_inc;
    end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game-flow controller for the pong family: lives, BCD scores, pause,
// frame-counted serve and game-over delays, winner reporting.
module game_ctrl_fsm
    import game_pkg::*;
#(
    parameter int               N_PLAYERS    = 1,
    parameter int               LIVES        = 3,
    parameter int               DIGITS       = 2,
    parameter logic [4*DIGITS-1:0] WIN_SCORE = '0,
    parameter int               SERVE_FRAMES = 120,
    parameter int               OVER_FRAMES  = 120,
    parameter logic [7:0]       PAUSE_KEY    = 8'h4D,
    localparam int              LIFE_W       = life_w(LIVES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic [15:0]                   key_code,
    input  logic [N_PLAYERS-1:0]          hit,
    input  logic [N_PLAYERS-1:0]          miss,
    output logic                          gra_still,
    output logic [2:0]                    state,
    output logic [N_PLAYERS*LIFE_W-1:0]   lives,
    output logic [N_PLAYERS*4*DIGITS-1:0] score,
    output logic [1:0]                    winner
);

    localparam int TIMER_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] SERVE_LD = TIMER_W'(SERVE_FRAMES);
    localparam logic [TIMER_W-1:0] OVER_LD  = TIMER_W'(OVER_FRAMES);
    localparam logic [N_PLAYERS-1:0][LIFE_W-1:0] LIVES_INIT = {N_PLAYERS{LIFE_W'(LIVES)}};

    game_state_t                           state_q, state_d;
    logic [TIMER_W-1:0]                    timer_q, timer_d;
    logic [N_PLAYERS-1:0][LIFE_W-1:0]      lives_q, lives_d;
    logic [N_PLAYERS-1:0][4*DIGITS-1:0]    score_q, score_nx;
    logic [1:0]                            winner_q, winner_d;
    logic [15:0]                           key_q;
    logic [N_PLAYERS-1:0]                  inc;
    logic                                  clr, press, pause_press, timer_up;
    logic [1:0]                            dead, won;

    // A held key repeats the same code, so only a change counts as a press.
    assign press = (key_code != key_q) && (key_code[15:8] != BREAK_CODE)
                && (key_code[7:0] != 8'h00);
    assign pause_press = press && (key_code[7:0] == PAUSE_KEY);
    assign timer_up    = (timer_q == '0);

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_score
        bcd_score_ctr #(.DIGITS(DIGITS)) u_score (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc[i]),
            .clr     (clr),
            .bcd     (score_q[i]),
            .bcd_inc (score_nx[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        lives_d  = lives_q;
        timer_d  = (frame_tick && !timer_up) ? timer_q - TIMER_W'(1) : timer_q;
        clr      = 1'b0;
        inc      = '0;
        dead     = '0;
        won      = '0;
        case (state_q)
            IDLE: begin
                clr     = 1'b1;
                lives_d = LIVES_INIT;
                if (press && !pause_press) begin
                    state_d  = PLAY;
                    winner_d = WIN_NONE;
                end
            end
            PLAY: begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (miss[i]) begin
                        if (lives_q[i] != '0) lives_d[i] = lives_q[i] - LIFE_W'(1);
                        dead[i] = (lives_q[i] == LIFE_W'(1));
                    end else if (hit[i]) begin
                        inc[i] = 1'b1;
                        won[i] = (WIN_SCORE != '0) && (score_nx[i] == WIN_SCORE);
                    end
                end
                // Final miss outranks a win; a lone loser hands the game to the other side.
                if (dead != 2'b00) begin
                    state_d = OVER;
                    if (N_PLAYERS == 1 || dead == 2'b11) winner_d = WIN_NONE;
                    else if (dead == 2'b01)              winner_d = WIN_P1;
                    else                                 winner_d = WIN_P0;
                end else if (won != 2'b00) begin
                    state_d = OVER;
                    if (won == 2'b01)      winner_d = WIN_P0;
                    else if (won == 2'b10) winner_d = WIN_P1;
                    else                   winner_d = WIN_NONE;
                end else if (|miss) begin
                    state_d = SERVE;
                end else if (pause_press && !(|hit)) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: if (pause_press) state_d = PLAY;
            SERVE: if (press && timer_up) state_d = PLAY;
            OVER: begin
                if (timer_up) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                    lives_d = LIVES_INIT;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q)
            timer_d = (state_d == SERVE) ? SERVE_LD :
                      (state_d == OVER)  ? OVER_LD  : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            lives_q  <= LIVES_INIT;
            winner_q <= WIN_NONE;
            key_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            lives_q  <= lives_d;
            winner_q <= winner_d;
            key_q    <= key_code;
        end
    end

    assign state     = state_q;
    assign gra_still = (state_q != PLAY);
    assign lives     = lives_q;
    assign score     = score_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Bench for game_ctrl_fsm: a 1-player and a 2-player (win at 05) instance,
// directed vectors and sequences plus random stimulus against an integer model.
module tb_game_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick1, tick2;
    logic [15:0] key1, key2;
    logic [0:0]  hit1, miss1;
    logic [1:0]  hit2, miss2;
    logic        gra1, gra2;
    logic [2:0]  state1, state2;
    logic [1:0]  lives1;
    logic [3:0]  lives2;
    logic [7:0]  score1;
    logic [15:0] score2;
    logic [1:0]  winner1, winner2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    game_ctrl_fsm dut1 (
        .clk(clk), .reset(reset), .frame_tick(tick1), .key_code(key1),
        .hit(hit1), .miss(miss1), .gra_still(gra1), .state(state1),
        .lives(lives1), .score(score1), .winner(winner1)
    );

    game_ctrl_fsm #(.N_PLAYERS(2), .WIN_SCORE(8'h05)) dut2 (
        .clk(clk), .reset(reset), .frame_tick(tick2), .key_code(key2),
        .hit(hit2), .miss(miss2), .gra_still(gra2), .state(state2),
        .lives(lives2), .score(score2), .winner(winner2)
    );

    // Reference model: plain integers, decimal scores, state numbers 0..4.
    int          NP[2]  = '{1, 2};
    int          WIN[2] = '{0, 5};
    int          m_st[2], m_wn[2], m_tm[2];
    int          m_lv[2][2], m_sc[2][2];
    logic [15:0] m_kq[2];

    function automatic int bcd2(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic m_clear(input int d);
        for (int p = 0; p < 2; p++) begin
            m_sc[d][p] = 0;
            m_lv[d][p] = (p < NP[d]) ? 3 : 0;
        end
    endtask

    task automatic m_reset(input int d);
        m_st[d] = 0; m_wn[d] = 0; m_tm[d] = 0; m_kq[d] = 16'h0;
        m_clear(d);
    endtask

    task automatic m_step(input int d, input logic [15:0] kc, input logic [1:0] h,
                          input logic [1:0] m, input logic t);
        bit press, pp, anyhit, anymiss;
        int nst, deadm, wonm;
        press = (kc != m_kq[d]) && (kc[15:8] != 8'hF0) && (kc[7:0] != 8'h00);
        pp    = press && (kc[7:0] == 8'h4D);
        m_kq[d] = kc;
        nst = m_st[d];
        case (m_st[d])
            0: begin
                m_clear(d);
                if (press && !pp) begin nst = 1; m_wn[d] = 0; end
            end
            1: begin
                deadm = 0; wonm = 0; anyhit = 0; anymiss = 0;
                for (int p = 0; p < NP[d]; p++) begin
                    if (h[p]) anyhit = 1;
                    if (m[p]) begin
                        anymiss = 1;
                        if (m_lv[d][p] == 1) deadm |= (1 << p);
                        if (m_lv[d][p] > 0) m_lv[d][p]--;
                    end else if (h[p]) begin
                        if (m_sc[d][p] < 99) m_sc[d][p]++;
                        if (WIN[d] != 0 && m_sc[d][p] == WIN[d]) wonm |= (1 << p);
                    end
                end
                if (deadm != 0) begin
                    nst = 4;
                    m_wn[d] = (NP[d] == 1 || deadm == 3) ? 0 : (deadm == 1 ? 2 : 1);
                end else if (wonm != 0) begin
                    nst = 4;
                    m_wn[d] = (wonm == 3) ? 0 : (wonm == 1 ? 1 : 2);
                end else if (anymiss) nst = 3;
                else if (pp && !anyhit) nst = 2;
            end
            2: if (pp) nst = 1;
            3: if (press && m_tm[d] == 0) nst = 1;
            4: if (m_tm[d] == 0) begin nst = 0; m_clear(d); end
            default: nst = 0;
        endcase
        if (nst != m_st[d]) m_tm[d] = (nst == 3 || nst == 4) ? 120 : 0;
        else if (t && m_tm[d] > 0) m_tm[d]--;
        m_st[d] = nst;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m1_state",  32'(state1),  32'(m_st[0]));
        chk("m1_gra",    32'(gra1),    32'(m_st[0] != 1));
        chk("m1_lives",  32'(lives1),  32'(m_lv[0][0]));
        chk("m1_score",  32'(score1),  32'(bcd2(m_sc[0][0])));
        chk("m1_winner", 32'(winner1), 32'(m_wn[0]));
        chk("m2_state",  32'(state2),  32'(m_st[1]));
        chk("m2_gra",    32'(gra2),    32'(m_st[1] != 1));
        chk("m2_lives",  32'(lives2),  32'(m_lv[1][0] | (m_lv[1][1] << 2)));
        chk("m2_score",  32'(score2),  32'(bcd2(m_sc[1][0]) | (bcd2(m_sc[1][1]) << 8)));
        chk("m2_winner", 32'(winner2), 32'(m_wn[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset) begin
            m_reset(0); m_reset(1);
        end else begin
            m_step(0, key1, {1'b0, hit1}, {1'b0, miss1}, tick1);
            m_step(1, key2, hit2, miss2, tick2);
        end
        #1;
        check_model();
    endtask

    task automatic frames(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            if (d == 0) tick1 = 1'b1; else tick2 = 1'b1;
            cyc();
            tick1 = 1'b0; tick2 = 1'b0;
            cyc();
        end
    endtask

    task automatic tap(input int d);
        if (d == 0) key1 = (key1 == 16'h0029) ? 16'h0033 : 16'h0029;
        else        key2 = (key2 == 16'h0029) ? 16'h0033 : 16'h0029;
        cyc();
    endtask

    typedef struct {
        logic [15:0] key;
        logic        hit;
        logic        miss;
        logic [2:0]  st;
        logic [7:0]  sc;
        logic [1:0]  lv;
        logic        gra;
    } vec_t;

    vec_t        tbl[9];
    logic [15:0] keys[8] = '{16'h0000, 16'h0029, 16'h0033, 16'h004D,
                             16'hF029, 16'hF04D, 16'h4D29, 16'h294D};

    initial begin
        tbl[0] = '{16'h0029, 1'b0, 1'b0, 3'd1, 8'h00, 2'd3, 1'b0};
        tbl[1] = '{16'h0029, 1'b1, 1'b0, 3'd1, 8'h01, 2'd3, 1'b0};
        tbl[2] = '{16'h0029, 1'b1, 1'b0, 3'd1, 8'h02, 2'd3, 1'b0};
        tbl[3] = '{16'h004D, 1'b0, 1'b0, 3'd2, 8'h02, 2'd3, 1'b1};
        tbl[4] = '{16'h004D, 1'b1, 1'b0, 3'd2, 8'h02, 2'd3, 1'b1};
        tbl[5] = '{16'hF04D, 1'b0, 1'b0, 3'd2, 8'h02, 2'd3, 1'b1};
        tbl[6] = '{16'h004D, 1'b0, 1'b0, 3'd1, 8'h02, 2'd3, 1'b0};
        tbl[7] = '{16'h004D, 1'b0, 1'b1, 3'd3, 8'h02, 2'd2, 1'b1};
        tbl[8] = '{16'h4D29, 1'b0, 1'b0, 3'd3, 8'h02, 2'd2, 1'b1};

        reset = 1'b0;
        tick1 = 0; tick2 = 0; key1 = 0; key2 = 0;
        hit1 = 0; miss1 = 0; hit2 = 0; miss2 = 0;
        m_reset(0); m_reset(1);
        cyc(); cyc();
        chk("rst_state", 32'(state1), 32'd0);
        chk("rst_lives", 32'(lives1), 32'd3);
        chk("rst_score", 32'(score1), 32'd0);
        chk("rst_gra",   32'(gra1),   32'd1);
        chk("rst_win2",  32'(winner2), 32'd0);
        reset = 1'b1;
        cyc();

        // Start, scoring, pause toggle and first miss on the 1-player unit.
        for (int i = 0; i < 9; i++) begin
            key1 = tbl[i].key; hit1 = tbl[i].hit; miss1 = tbl[i].miss;
            cyc();
            chk($sformatf("vec%0d_state", i), 32'(state1), 32'(tbl[i].st));
            chk($sformatf("vec%0d_score", i), 32'(score1), 32'(tbl[i].sc));
            chk($sformatf("vec%0d_lives", i), 32'(lives1), 32'(tbl[i].lv));
            chk($sformatf("vec%0d_gra", i),   32'(gra1),   32'(tbl[i].gra));
        end
        hit1 = 0; miss1 = 0;

        // Serve gate: early press dropped, held key never counts.
        frames(0, 10);
        key1 = 16'h0033; cyc();
        chk("serve_early", 32'(state1), 32'd3);
        frames(0, 115); cyc();
        chk("serve_held", 32'(state1), 32'd3);
        key1 = 16'hF033; cyc();
        key1 = 16'h0034; cyc();
        chk("serve_new_press", 32'(state1), 32'd1);

        // Press on the same cycle the timer reaches zero is not accepted.
        miss1 = 1; cyc(); miss1 = 0;
        chk("serve2_lives", 32'(lives1), 32'd1);
        frames(0, 119);
        key1 = 16'h0029; tick1 = 1; cyc(); tick1 = 0;
        chk("serve_edge_press", 32'(state1), 32'd3);
        key1 = 16'h0033; cyc();
        chk("serve_after_edge", 32'(state1), 32'd1);

        // Score saturation, final miss, game-over delay.
        hit1 = 1;
        repeat (97) cyc();
        chk("score_99", 32'(score1), 32'h99);
        cyc();
        chk("score_sat", 32'(score1), 32'h99);
        hit1 = 0;
        miss1 = 1; cyc(); miss1 = 0;
        chk("over_state", 32'(state1), 32'd4);
        chk("over_lives", 32'(lives1), 32'd0);
        chk("over_winner", 32'(winner1), 32'd0);
        frames(0, 119);
        chk("over_hold", 32'(state1), 32'd4);
        frames(0, 1);
        chk("idle_state", 32'(state1), 32'd0);
        chk("idle_score", 32'(score1), 32'd0);
        chk("idle_lives", 32'(lives1), 32'd3);

        // Async reset mid-game, checked before any clock edge.
        key1 = 16'h0029; cyc();
        hit1 = 1; repeat (12) cyc(); hit1 = 0;
        chk("pre_rst_score", 32'(score1), 32'h12);
        #2 reset = 1'b0;
        #1;
        chk("arst_state", 32'(state1), 32'd0);
        chk("arst_score", 32'(score1), 32'd0);
        chk("arst_lives", 32'(lives1), 32'd3);
        key1 = 16'h0000;
        cyc();
        reset = 1'b1;
        cyc();

        // 2-player: P1 reaches the win score.
        key2 = 16'h0029; cyc();
        chk("p2_start", 32'(state2), 32'd1);
        hit2 = 2'b10; repeat (5) cyc(); hit2 = 0;
        chk("p2_win_state", 32'(state2), 32'd4);
        chk("p2_win_who", 32'(winner2), 32'b10);
        chk("p2_win_score", 32'(score2), 32'h0500);
        frames(1, 120);
        chk("p2_idle", 32'(state2), 32'd0);

        // 2-player: hit+miss on one player, then both players run out together.
        key2 = 16'h0033; cyc();
        hit2 = 2'b01; miss2 = 2'b01; cyc(); hit2 = 0; miss2 = 0;
        chk("hm_state", 32'(state2), 32'd3);
        chk("hm_lives", 32'(lives2), 32'b1110);
        chk("hm_score", 32'(score2), 32'h0000);
        frames(1, 120); tap(1);
        miss2 = 2'b10; cyc(); miss2 = 0;
        chk("m10_lives", 32'(lives2), 32'b1010);
        frames(1, 120); tap(1);
        miss2 = 2'b11; cyc(); miss2 = 0;
        chk("m11_lives", 32'(lives2), 32'b0101);
        frames(1, 120); tap(1);
        chk("p2_play", 32'(state2), 32'd1);
        miss2 = 2'b11; cyc(); miss2 = 0;
        chk("tie_state", 32'(state2), 32'd4);
        chk("tie_winner", 32'(winner2), 32'd0);
        chk("tie_lives", 32'(lives2), 32'd0);
        frames(1, 120);

        // Random traffic on both units against the model.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(5) == 0) key1 = keys[$urandom_range(7)];
            if ($urandom_range(5) == 0) key2 = keys[$urandom_range(7)];
            hit1  = ($urandom_range(5) == 0);
            miss1 = ($urandom_range(39) == 0);
            tick1 = ($urandom_range(2) == 0);
            for (int p = 0; p < 2; p++) begin
                hit2[p]  = ($urandom_range(5) == 0);
                miss2[p] = ($urandom_range(39) == 0);
            end
            tick2 = ($urandom_range(2) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
